// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined CLA adder/subtractor family.
// Slice width, slice count helper and the single-bit full-adder cell.
package adder_pkg;

    localparam int unsigned CLA_SLICE = 4;

    function automatic int unsigned num_slices(input int unsigned width);
        return (width + CLA_SLICE - 1) / CLA_SLICE;
    endfunction

    // Returns {carry_out, sum}
    function automatic logic [1:0] full_adder(input logic a, input logic b, input logic cin);
        return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/cl_adder_4.sv
// 4-bit carry-lookahead adder cell, purely combinational.
module cl_adder_4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Flattened lookahead carries
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum  = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];

endmodule

// File: rtl/pl_sub_stage.sv
// One registered 4-bit subtract slice. The x bus carries finished difference bits
// below the slice and untouched minuend bits above it; b carries only unconsumed bits.
module pl_sub_stage
    import adder_pkg::*;
#(
    parameter int unsigned C_WIDTH = 32,
    parameter int unsigned IDX     = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_en,
    input  logic                                  i_valid,
    input  logic                                  i_carry,
    input  logic [C_WIDTH-1:0]                    i_x,
    input  logic [C_WIDTH-CLA_SLICE*IDX-1:0]      i_b,
    output logic                                  o_valid,
    output logic                                  o_carry,
    output logic [C_WIDTH-1:0]                    o_x,
    output logic [C_WIDTH-CLA_SLICE*(IDX+1)-1:0]  o_b
);

    localparam int unsigned LSB = CLA_SLICE * IDX;
    localparam int unsigned BW  = C_WIDTH - LSB;

    logic [CLA_SLICE-1:0]    w_sum;
    logic                    w_cout;
    logic [C_WIDTH-1:0]      w_x;
    logic                    r_valid;
    logic                    r_carry;
    logic [C_WIDTH-1:0]      r_x;
    logic [BW-CLA_SLICE-1:0] r_b;

    cl_adder_4 u_cla (
        .i_a    (i_x[LSB +: CLA_SLICE]),
        .i_b    (~i_b[CLA_SLICE-1:0]),
        .i_cin  (i_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_comb begin
        w_x                     = i_x;
        w_x[LSB +: CLA_SLICE]   = w_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
        end
    end

    // Data only moves with an accepted token
    always_ff @(posedge clk) begin
        if (i_en && i_valid) begin
            r_x     <= w_x;
            r_b     <= i_b[BW-1:CLA_SLICE];
            r_carry <= w_cout;
        end
    end

    assign o_valid = r_valid;
    assign o_carry = r_carry;
    assign o_x     = r_x;
    assign o_b     = r_b;

endmodule

// File: rtl/pl_cl_subtractor.sv
// Pipelined unsigned subtractor y = a - b, one CLA slice per stage, valid/ready handshake.
// Define PL_SUB_SATURATE_EN to clamp the difference to 0 when a < b.
module pl_cl_subtractor
    import adder_pkg::*;
#(
    parameter int unsigned C_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [C_WIDTH-1:0] s_a,
    input  logic [C_WIDTH-1:0] s_b,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [C_WIDTH-1:0] m_diff,
    output logic               m_borrow
);

    localparam int unsigned NUM_STAGES = num_slices(C_WIDTH);
    // Last slice is computed in front of the output register
    localparam int unsigned PIPE       = NUM_STAGES - 1;
    localparam int unsigned TOP_W      = C_WIDTH - CLA_SLICE * PIPE;

    logic               w_en;
    logic               w_top_valid;
    logic               w_top_carry;
    logic [C_WIDTH-1:0] w_top_x;
    logic [TOP_W-1:0]   w_top_b;
    logic [TOP_W-1:0]   w_top_a;
    logic [TOP_W-1:0]   w_top_sum;
    logic               w_top_cout;
    logic [C_WIDTH-1:0] w_diff;
    logic [C_WIDTH-1:0] w_diff_out;
    logic               r_m_valid;
    logic [C_WIDTH-1:0] r_m_diff;
    logic               r_m_borrow;

    assign w_en    = ~(r_m_valid & ~m_ready);
    assign s_ready = w_en;

    for (genvar k = 0; k < PIPE; k++) begin : g_stage
        localparam int unsigned BW = C_WIDTH - CLA_SLICE * k;

        logic                    w_in_valid;
        logic                    w_in_carry;
        logic [C_WIDTH-1:0]      w_in_x;
        logic [BW-1:0]           w_in_b;
        logic                    w_valid;
        logic                    w_carry;
        logic [C_WIDTH-1:0]      w_x;
        logic [BW-CLA_SLICE-1:0] w_b;

        if (k == 0) begin : g_src
            assign w_in_valid = s_valid;
            assign w_in_carry = 1'b1;
            assign w_in_x     = s_a;
            assign w_in_b     = s_b;
        end else begin : g_src
            assign w_in_valid = g_stage[k-1].w_valid;
            assign w_in_carry = g_stage[k-1].w_carry;
            assign w_in_x     = g_stage[k-1].w_x;
            assign w_in_b     = g_stage[k-1].w_b;
        end

        pl_sub_stage #(
            .C_WIDTH (C_WIDTH),
            .IDX     (k)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .i_en    (w_en),
            .i_valid (w_in_valid),
            .i_carry (w_in_carry),
            .i_x     (w_in_x),
            .i_b     (w_in_b),
            .o_valid (w_valid),
            .o_carry (w_carry),
            .o_x     (w_x),
            .o_b     (w_b)
        );
    end

    if (PIPE == 0) begin : g_top_src
        assign w_top_valid = s_valid;
        assign w_top_carry = 1'b1;
        assign w_top_x     = s_a;
        assign w_top_b     = s_b;
    end else begin : g_top_src
        assign w_top_valid = g_stage[PIPE-1].w_valid;
        assign w_top_carry = g_stage[PIPE-1].w_carry;
        assign w_top_x     = g_stage[PIPE-1].w_x;
        assign w_top_b     = g_stage[PIPE-1].w_b;
    end

    assign w_top_a = w_top_x[C_WIDTH-1 -: TOP_W];

    if (TOP_W == CLA_SLICE) begin : g_top_cla
        cl_adder_4 u_cla (
            .i_a    (w_top_a),
            .i_b    (~w_top_b),
            .i_cin  (w_top_carry),
            .o_sum  (w_top_sum),
            .o_cout (w_top_cout)
        );
    end else begin : g_top_ripple
        // Narrow top slice: plain ripple of full-adder cells
        always_comb begin
            logic [TOP_W:0] v_c;
            v_c        = '0;
            w_top_sum  = '0;
            v_c[0]     = w_top_carry;
            for (int i = 0; i < int'(TOP_W); i++) begin
                {v_c[i+1], w_top_sum[i]} = full_adder(w_top_a[i], ~w_top_b[i], v_c[i]);
            end
            w_top_cout = v_c[TOP_W];
        end
    end

    if (PIPE == 0) begin : g_diff
        assign w_diff = w_top_sum;
    end else begin : g_diff
        assign w_diff = {w_top_sum, w_top_x[C_WIDTH-TOP_W-1:0]};
    end

`ifdef PL_SUB_SATURATE_EN
    assign w_diff_out = w_top_cout ? w_diff : '0;
`else
    assign w_diff_out = w_diff;
`endif

    // Output register; holds steady while downstream stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid  <= 1'b0;
            r_m_diff   <= '0;
            r_m_borrow <= 1'b0;
        end else if (w_en) begin
            r_m_valid <= w_top_valid;
            if (w_top_valid) begin
                r_m_diff   <= w_diff_out;
                r_m_borrow <= ~w_top_cout;
            end
        end
    end

    assign m_valid  = r_m_valid;
    assign m_diff   = r_m_diff;
    assign m_borrow = r_m_borrow;

endmodule

// File: tb/tb_pl_cl_subtractor.sv
// Scoreboard bench for pl_cl_subtractor (32-bit) plus a 30-bit instance for the narrow top slice.
module tb_pl_cl_subtractor;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid, s_ready, m_valid, m_ready, m_borrow;
    logic [31:0] s_a, s_b, m_diff;
    logic        s_valid30, s_ready30, m_valid30, m_borrow30;
    logic [29:0] s_a30, s_b30, m_diff30;
    logic        m_ready30 = 1'b1;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [32:0] q[$];
    logic [32:0] e;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_out;
    logic        stream_done;

    always #5 clk = ~clk;

    pl_cl_subtractor #(.C_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .m_valid(m_valid), .m_ready(m_ready), .m_diff(m_diff), .m_borrow(m_borrow)
    );

    pl_cl_subtractor #(.C_WIDTH(30)) dut30 (
        .clk(clk), .reset(reset), .s_valid(s_valid30), .s_ready(s_ready30), .s_a(s_a30), .s_b(s_b30),
        .m_valid(m_valid30), .m_ready(m_ready30), .m_diff(m_diff30), .m_borrow(m_borrow30)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d  = a - b;
        logic        br = (a < b);
`ifdef PL_SUB_SATURATE_EN
        if (br) d = '0;
`endif
        return {br, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bit done = 1'b0;
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge clk);
            done = s_ready;
            tick();
        end
        s_valid = 1'b0;
        if (!done) check("send_timeout", 64'(done), 64'd1);
    endtask

    task automatic latency(output int cnt);
        cnt = 1;
        while (!m_valid && cnt < 50) begin
            tick();
            cnt++;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 2000 && q.size() != 0; t++) begin
            tick();
        end
        check("drain", 64'(q.size()), 64'd0);
    endtask

    // Scoreboard: push on input transfer, pop on output transfer, plus handshake invariants
    always @(negedge clk) begin
        check("s_ready_rule", 64'(s_ready), 64'(!(m_valid && !m_ready)));
        if (reset) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("stall_hold", {31'd0, m_valid, m_borrow, m_diff}, {31'd0, 1'b1, prev_out});
            if (s_valid && s_ready) q.push_back(model(s_a, s_b));
            if (m_valid && m_ready) begin
                check("sb_nonempty", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("diff", 64'(m_diff), 64'(e[31:0]));
                    check("borrow", 64'(m_borrow), 64'(e[32]));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_out   = {m_borrow, m_diff};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int run;
        bit ok;
        reset = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b1;
        s_valid30 = 1'b0; s_a30 = '0; s_b30 = '0;
        repeat (3) tick();
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_diff", 64'(m_diff), 64'd0);
        check("rst_m_borrow", 64'(m_borrow), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_m_valid30", 64'(m_valid30), 64'd0);
        reset = 1'b0;
        tick();

        // Single token and latency
        send(32'd100, 32'd58);
        latency(cnt);
        check("latency", 64'(cnt), 64'd8);
        drain();

        // Boundaries
        send(32'd0, 32'hFFFF_FFFF);
        send(32'd12345, 32'd12345);
        send(32'hDEAD_BEEF, 32'd0);
        send(32'hFFFF_FFFF, 32'd1);
        send(32'h0000_0010, 32'h0000_0011);
        drain();

        // Back-to-back stream, outputs must be gapless
        run = 0;
        fork
            for (int i = 0; i < 64; i++) send(32'(i * 1000), 32'(i));
            begin
                for (int t = 0; t < 100 && !m_valid; t++) tick();
                while (m_valid && run < 200) begin
                    run++;
                    tick();
                end
            end
        join
        check("stream_run", 64'(run), 64'd64);
        drain();

        // Same stream under random backpressure
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 64; i++) send(32'(i * 1000), 32'(i));
                stream_done = 1'b1;
            end
            while (!stream_done) begin
                m_ready = ($urandom_range(0, 99) >= 30);
                tick();
            end
        join
        for (int t = 0; t < 2000 && q.size() != 0; t++) begin
            m_ready = ($urandom_range(0, 99) >= 30);
            tick();
        end
        m_ready = 1'b1;
        drain();

        // Reset with tokens in flight
        for (int i = 1; i <= 5; i++) send(32'(i * 11), 32'(i));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ok = 1'b1;
        repeat (12) begin
            if (m_valid) ok = 1'b0;
            tick();
        end
        check("rst_flush", 64'(ok), 64'd1);
        send(32'd777, 32'd77);
        latency(cnt);
        check("latency_post_rst", 64'(cnt), 64'd8);
        drain();

        // 30-bit build: 2-bit top slice
        s_valid30 = 1'b1; s_a30 = 30'h2000_0000; s_b30 = 30'd1;
        check("s_ready30", 64'(s_ready30), 64'd1);
        tick();
        s_valid30 = 1'b0;
        cnt = 1;
        while (!m_valid30 && cnt < 50) begin tick(); cnt++; end
        check("latency30", 64'(cnt), 64'd8);
        check("diff30_a", 64'(m_diff30), 64'h1FFF_FFFF);
        check("borrow30_a", 64'(m_borrow30), 64'd0);
        tick();
        s_valid30 = 1'b1; s_a30 = 30'd5; s_b30 = 30'd6;
        tick();
        s_valid30 = 1'b0;
        cnt = 1;
        while (!m_valid30 && cnt < 50) begin tick(); cnt++; end
        check("latency30_b", 64'(cnt), 64'd8);
`ifdef PL_SUB_SATURATE_EN
        check("diff30_b", 64'(m_diff30), 64'd0);
`else
        check("diff30_b", 64'(m_diff30), 64'h3FFF_FFFF);
`endif
        check("borrow30_b", 64'(m_borrow30), 64'd1);

        check("sb_final_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
